// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice:
//   - sel[3:2] operation-class field values
//   - sel[1:0] sub-op codes for the arithmetic B-mux and the logic ops
//   - sequencer FSM state type
package alu_pkg;

  // sel[3:2]: operation class
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_SHR   = 2'b10;
  localparam logic [1:0] SEL_SHL   = 2'b11;

  // sel[1:0] in the arithmetic class: selects the B-mux operand
  localparam logic [1:0] ADD_ZERO  = 2'b00;
  localparam logic [1:0] ADD_B     = 2'b01;
  localparam logic [1:0] ADD_NOTB  = 2'b10;
  localparam logic [1:0] ADD_ONES  = 2'b11;

  // sel[1:0] in the logic class
  localparam logic [1:0] AND       = 2'b00;
  localparam logic [1:0] OR        = 2'b01;
  localparam logic [1:0] XOR       = 2'b10;
  localparam logic [1:0] NOT       = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_1bit.sv
// alu_1bit
// One bit slice of the ALU. Purely combinational.
// Ports:
//   ai_i, bi_i   : operand bits A[i], B[i]
//   cini_i       : carry into this bit
//   a_prev_i     : A[i+1] (source bit for shift right)
//   a_next_i     : A[i-1] (source bit for shift left)
//   sel_i[3:0]   : op code (class in [3:2], sub-op in [1:0])
//   fi_o         : result bit
//   couti_o      : carry out (arithmetic class only, 0 otherwise)
module alu_1bit
  import alu_pkg::*;
(
  input  logic       ai_i,
  input  logic       bi_i,
  input  logic       cini_i,
  input  logic       a_prev_i,
  input  logic       a_next_i,
  input  logic [3:0] sel_i,
  output logic       fi_o,
  output logic       couti_o
);

  logic bm_s;

  // B-mux for the arithmetic class
  always_comb begin
    bm_s = 1'b0;
    case (sel_i[1:0])
      ADD_ZERO: bm_s = 1'b0;
      ADD_B:    bm_s = bi_i;
      ADD_NOTB: bm_s = ~bi_i;
      ADD_ONES: bm_s = 1'b1;
      default:  bm_s = 1'b0;
    endcase
  end

  // Result bit and carry out for the selected class
  always_comb begin
    fi_o    = 1'b0;
    couti_o = 1'b0;
    case (sel_i[3:2])
      SEL_ARITH: begin
        fi_o    = ai_i ^ bm_s ^ cini_i;
        couti_o = (ai_i & bm_s) | (ai_i & cini_i) | (bm_s & cini_i);
      end
      SEL_LOGIC: begin
        case (sel_i[1:0])
          AND:     fi_o = ai_i & bi_i;
          OR:      fi_o = ai_i | bi_i;
          XOR:     fi_o = ai_i ^ bi_i;
          NOT:     fi_o = ~ai_i;
          default: fi_o = 1'b0;
        endcase
      end
      SEL_SHR: fi_o = a_prev_i;
      SEL_SHL: fi_o = a_next_i;
      default: fi_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq
// Executes one W-bit ALU operation over W cycles through a single alu_1bit
// slice, LSB first, with the slice carry registered between cycles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   op_valid / op_ready   : request handshake; a, b, sel, cin latched on accept
//   res_valid / res_ready : response handshake; held in DONE until consumed
//   result, cout, ovf, zero : registered results, stable while res_valid
module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   sel,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    sel_q, sel_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          op_ready_q, op_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic          ai_s, bi_s, a_prev_s, a_next_s;
  logic          fi_s, couti_s;
  logic          arith_s, last_s;
  logic [W-1:0]  shifted_s;

  // Slice operand selection for the current bit index
  always_comb begin
    ai_s     = a_q[cnt_q];
    bi_s     = b_q[cnt_q];
    last_s   = (cnt_q == CW'(W - 1));
    arith_s  = (sel_q[3:2] == SEL_ARITH);
    // Neighbour bits fall off the ends of the operand as zeros
    if (last_s) begin
      a_prev_s = 1'b0;
    end else begin
      a_prev_s = a_q[cnt_q + CW'(1)];
    end
    if (cnt_q == {CW{1'b0}}) begin
      a_next_s = 1'b0;
    end else begin
      a_next_s = a_q[cnt_q - CW'(1)];
    end
  end

  alu_1bit u_slice (
    .ai_i     (ai_s),
    .bi_i     (bi_s),
    .cini_i   (carry_q),
    .a_prev_i (a_prev_s),
    .a_next_i (a_next_s),
    .sel_i    (sel_q),
    .fi_o     (fi_s),
    .couti_o  (couti_s)
  );

  // New bit enters at the MSB so bit 0 ends up at the bottom after W shifts
  assign shifted_s = {fi_s, sr_q[W-1:1]};

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    carry_d     = carry_q;
    sr_d        = sr_q;
    op_ready_d  = op_ready_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d        = a;
          b_d        = b;
          sel_d      = sel;
          carry_d    = cin;
          cnt_d      = {CW{1'b0}};
          op_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        sr_d = shifted_s;
        if (arith_s) begin
          carry_d = couti_s;
        end else begin
          carry_d = 1'b0;
        end
        if (last_s) begin
          // carry_q here is the carry into the MSB, couti_s the carry out of it
          result_d    = shifted_s;
          cout_d      = arith_s & couti_s;
          ovf_d       = arith_s & (carry_q ^ couti_s);
          zero_d      = (shifted_s == {W{1'b0}});
          res_valid_d = 1'b1;
          cnt_d       = {CW{1'b0}};
          state_d     = DONE;
        end else begin
          cnt_d       = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        op_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sel_q       <= 4'b0000;
      carry_q     <= 1'b0;
      sr_q        <= {W{1'b0}};
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      result_q    <= {W{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      carry_q     <= carry_d;
      sr_q        <= sr_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
